branch_resolve_unit: RTL and testbench

- Consumer side of the branch comparator.
- Drives BrUn from funct3 and consumes BrEq/BrLT, then decides taken/not-taken for conditional branches, JAL and JALR in EX.
- Checks the decision against the fetch-stage prediction.
- Issues a registered redirect/flush to fetch with a valid/ready handshake, sends a predictor update, and keeps branch/mispredict counters.

---
 rtl/branch_resolve_unit_pkg.sv | 22 ++
 rtl/branch_resolve_unit_br_cond_decode.sv | 33 +++
 rtl/branch_resolve_unit.sv | 174 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the branch resolve unit.
//   - default datapath width
//   - conditional-branch funct3 encodings
//   - resolve FSM state encoding
package branch_resolve_unit_pkg;

  localparam int DEF_DATA_BITS = 64;

  localparam logic [2:0] BR_BEQ  = 3'b000;
  localparam logic [2:0] BR_BNE  = 3'b001;
  localparam logic [2:0] BR_BLT  = 3'b100;
  localparam logic [2:0] BR_BGE  = 3'b101;
  localparam logic [2:0] BR_BLTU = 3'b110;
  localparam logic [2:0] BR_BGEU = 3'b111;

  typedef enum logic [1:0] {
    RSLV_IDLE     = 2'd0,
    RSLV_REDIRECT = 2'd1,
    RSLV_WAIT     = 2'd2
  } rslv_state_e;

endpackage

// File: rtl/branch_resolve_unit_br_cond_decode.sv
// br_cond_decode: combinational branch-condition decode.
// Ports:
//   funct3  in   branch condition code
//   BrEq    in   comparator equal result
//   BrLT    in   comparator less-than result (signed/unsigned per BrUn)
//   BrUn    out  request unsigned compare (BLTU/BGEU)
//   taken   out  condition satisfied
//   illegal out  funct3 is not a defined branch condition (010/011)
module br_cond_decode (
  input  logic [2:0] funct3,
  input  logic       BrEq,
  input  logic       BrLT,
  output logic       BrUn,
  output logic       taken,
  output logic       illegal
);
  import branch_resolve_unit_pkg::*;

  assign BrUn = (funct3 == BR_BLTU) || (funct3 == BR_BGEU);

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      BR_BEQ:           taken = BrEq;
      BR_BNE:           taken = !BrEq;
      BR_BLT, BR_BLTU:  taken = BrLT;
      BR_BGE, BR_BGEU:  taken = !BrLT;
      default:          illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: resolves control transfers in EX, checks them against
// the fetch prediction, and issues a registered redirect/flush, predictor
// update and performance counts.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      EX candidate handshake
//   is_branch/is_jal/is_jalr one-hot instruction class
//   funct3, pc, imm, rs1_val instruction fields/operands
//   BrUn / BrEq, BrLT        comparator control and results
//   pred_taken, pred_target  fetch-stage prediction
//   redirect_*               corrected-PC request to fetch (valid/ready)
//   flush                    one-cycle kill of IF/ID
//   upd_*                    predictor update pulse
//   misalign_exc, illegal_br one-cycle exception pulses
//   branch_cnt, mispred_cnt  saturating performance counters
//
// state    | meaning
// IDLE     | ready for a new control transfer
// REDIRECT | first redirect cycle (flush pulses here)
// WAIT     | redirect held until fetch accepts it
module branch_resolve_unit #(
  parameter int DATA_BITS = branch_resolve_unit_pkg::DEF_DATA_BITS,
  parameter int CNT_BITS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 is_branch,
  input  logic                 is_jal,
  input  logic                 is_jalr,
  input  logic [2:0]           funct3,
  input  logic [DATA_BITS-1:0] pc,
  input  logic [DATA_BITS-1:0] imm,
  input  logic [DATA_BITS-1:0] rs1_val,
  output logic                 BrUn,
  input  logic                 BrEq,
  input  logic                 BrLT,
  input  logic                 pred_taken,
  input  logic [DATA_BITS-1:0] pred_target,
  output logic                 redirect_valid,
  input  logic                 redirect_ready,
  output logic [DATA_BITS-1:0] redirect_pc,
  output logic                 flush,
  output logic                 upd_valid,
  output logic [DATA_BITS-1:0] upd_pc,
  output logic                 upd_taken,
  output logic [DATA_BITS-1:0] upd_target,
  output logic                 misalign_exc,
  output logic                 illegal_br,
  output logic [CNT_BITS-1:0]  branch_cnt,
  output logic [CNT_BITS-1:0]  mispred_cnt
);
  import branch_resolve_unit_pkg::*;

  rslv_state_e state_q, state_d;

  logic [DATA_BITS-1:0] redirect_pc_q, redirect_pc_d;
  logic [DATA_BITS-1:0] upd_pc_q, upd_pc_d;
  logic [DATA_BITS-1:0] upd_target_q, upd_target_d;
  logic                 upd_taken_q, upd_taken_d;
  logic                 upd_valid_q, upd_valid_d;
  logic                 flush_q, flush_d;
  logic                 misalign_q, misalign_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_BITS-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_BITS-1:0]  mispred_cnt_q, mispred_cnt_d;

  logic                 cond_taken, cond_illegal;
  logic                 accept, taken, misaligned, mispredict, do_redirect;
  logic [DATA_BITS-1:0] jalr_sum, target, seq_pc, next_pc;

  br_cond_decode u_cond (
    .funct3  (funct3),
    .BrEq    (BrEq),
    .BrLT    (BrLT),
    .BrUn    (BrUn),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign in_ready = (state_q == RSLV_IDLE);
  assign accept   = in_valid && in_ready && (is_branch || is_jal || is_jalr);

  always_comb begin
    taken       = is_branch ? cond_taken : 1'b1;
    jalr_sum    = rs1_val + imm;
    // JALR clears bit 0 of the computed address
    target      = is_jalr ? (jalr_sum & {{(DATA_BITS-1){1'b1}}, 1'b0}) : (pc + imm);
    seq_pc      = pc + DATA_BITS'(4);
    next_pc     = taken ? target : seq_pc;
    misaligned  = taken && (target[1:0] != 2'b00);
    mispredict  = (taken != pred_taken) || (taken && (target != pred_target));
    // a misaligned taken target raises an exception instead of redirecting
    do_redirect = accept && mispredict && !misaligned;
  end

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    upd_pc_d      = upd_pc_q;
    upd_target_d  = upd_target_q;
    upd_taken_d   = upd_taken_q;
    upd_valid_d   = 1'b0;
    flush_d       = 1'b0;
    misalign_d    = 1'b0;
    illegal_d     = 1'b0;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    case (state_q)
      RSLV_IDLE:     if (do_redirect) state_d = RSLV_REDIRECT;
      RSLV_REDIRECT: state_d = redirect_ready ? RSLV_IDLE : RSLV_WAIT;
      RSLV_WAIT:     if (redirect_ready) state_d = RSLV_IDLE;
      default:       state_d = RSLV_IDLE;
    endcase

    if (accept) begin
      upd_valid_d  = 1'b1;
      upd_pc_d     = pc;
      upd_taken_d  = taken;
      upd_target_d = target;
      misalign_d   = misaligned;
      illegal_d    = is_branch && cond_illegal;
      if (branch_cnt_q != {CNT_BITS{1'b1}}) branch_cnt_d = branch_cnt_q + CNT_BITS'(1);
      if (do_redirect) begin
        redirect_pc_d = next_pc;
        flush_d       = 1'b1;
        if (mispred_cnt_q != {CNT_BITS{1'b1}}) mispred_cnt_d = mispred_cnt_q + CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RSLV_IDLE;
      redirect_pc_q <= '0;
      upd_pc_q      <= '0;
      upd_target_q  <= '0;
      upd_taken_q   <= 1'b0;
      upd_valid_q   <= 1'b0;
      flush_q       <= 1'b0;
      misalign_q    <= 1'b0;
      illegal_q     <= 1'b0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      upd_pc_q      <= upd_pc_d;
      upd_target_q  <= upd_target_d;
      upd_taken_q   <= upd_taken_d;
      upd_valid_q   <= upd_valid_d;
      flush_q       <= flush_d;
      misalign_q    <= misalign_d;
      illegal_q     <= illegal_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign redirect_valid = (state_q != RSLV_IDLE);
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign upd_valid      = upd_valid_q;
  assign upd_pc         = upd_pc_q;
  assign upd_taken      = upd_taken_q;
  assign upd_target     = upd_target_q;
  assign misalign_exc   = misalign_q;
  assign illegal_br     = illegal_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        is_branch, is_jal, is_jalr;
  logic [2:0]  funct3;
  logic [63:0] pc, imm, rs1_val;
  logic        BrUn, BrEq, BrLT;
  logic        pred_taken;
  logic [63:0] pred_target;
  logic        redirect_valid, redirect_ready;
  logic [63:0] redirect_pc;
  logic        flush, upd_valid, upd_taken;
  logic [63:0] upd_pc, upd_target;
  logic        misalign_exc, illegal_br;
  logic [31:0] branch_cnt, mispred_cnt;

  branch_resolve_unit #(.DATA_BITS(64), .CNT_BITS(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .funct3(funct3), .pc(pc), .imm(imm), .rs1_val(rs1_val),
    .BrUn(BrUn), .BrEq(BrEq), .BrLT(BrLT),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .misalign_exc(misalign_exc),
    .illegal_br(illegal_br), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] upd_pc;
    logic [63:0] upd_target;
    logic [63:0] redirect_pc;
    bit          taken;
    bit          misal;
    bit          illeg;
    bit          redir;
    int unsigned bcnt;
    int unsigned mcnt;
  } exp_t;

  exp_t        sb[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned m_bcnt  = 0;
  int unsigned m_mcnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: outcome of one control transfer from the ISA rules.
  function automatic exp_t predict(input bit br, input bit jal, input bit jalr,
                                   input logic [2:0] f3, input logic [63:0] pc_i,
                                   input logic [63:0] imm_i, input logic [63:0] rs1_i,
                                   input bit eq, input bit lt, input bit pt,
                                   input logic [63:0] ptgt);
    exp_t e;
    logic [63:0] tgt;
    bit tk, mp;
    tk = 1'b0;
    if (jal || jalr) tk = 1'b1;
    else begin
      case (f3)
        3'd0: tk = eq;
        3'd1: tk = !eq;
        3'd4, 3'd6: tk = lt;
        3'd5, 3'd7: tk = !lt;
        default: tk = 1'b0;
      endcase
    end
    tgt = jalr ? ((rs1_i + imm_i) & ~64'h1) : (pc_i + imm_i);
    e.upd_pc      = pc_i;
    e.upd_target  = tgt;
    e.taken       = tk;
    e.misal       = tk && (tgt[1:0] != 2'b00);
    e.illeg       = br && (f3 == 3'd2 || f3 == 3'd3);
    mp            = (tk != pt) || (tk && tgt != ptgt);
    e.redir       = mp && !e.misal;
    e.redirect_pc = tk ? tgt : pc_i + 64'd4;
    e.bcnt        = 0;
    e.mcnt        = 0;
    return e;
  endfunction

  // Monitor: compares every update the DUT presents against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (upd_valid) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_upd: got upd_valid=1 expected no update (t=%0t)", $time);
          end else begin
            e = sb.pop_front();
            chk("upd_pc",       upd_pc,         e.upd_pc);
            chk("upd_taken",    upd_taken,      64'(e.taken));
            chk("upd_target",   upd_target,     e.upd_target);
            chk("misalign_exc", misalign_exc,   64'(e.misal));
            chk("illegal_br",   illegal_br,     64'(e.illeg));
            chk("flush",        flush,          64'(e.redir));
            chk("redirect_vld", redirect_valid, 64'(e.redir));
            if (e.redir) chk("redirect_pc", redirect_pc, e.redirect_pc);
            chk("branch_cnt",   branch_cnt,     64'(e.bcnt));
            chk("mispred_cnt",  mispred_cnt,    64'(e.mcnt));
          end
        end else begin
          chk("idle_pulses", {61'd0, flush, misalign_exc, illegal_br}, 64'd0);
        end
      end
    end
  end

  task automatic clear_inputs();
    in_valid = 0; is_branch = 0; is_jal = 0; is_jalr = 0; funct3 = 0;
    pc = 0; imm = 0; rs1_val = 0; BrEq = 0; BrLT = 0;
    pred_taken = 0; pred_target = 0;
  endtask

  // hold_n >= 0: fetch stalls hold_n cycles then accepts the redirect.
  // hold_n <  0: leave the unit in WAIT without accepting.
  task automatic issue(input bit br, input bit jal, input bit jalr, input logic [2:0] f3,
                       input logic [63:0] pc_i, input logic [63:0] imm_i,
                       input logic [63:0] rs1_i, input bit eq, input bit lt,
                       input bit pt, input logic [63:0] ptgt, input int hold_n);
    exp_t e;
    bit   acc;
    int   last;
    in_valid = 1; is_branch = br; is_jal = jal; is_jalr = jalr; funct3 = f3;
    pc = pc_i; imm = imm_i; rs1_val = rs1_i; BrEq = eq; BrLT = lt;
    pred_taken = pt; pred_target = ptgt;
    #1;
    chk("br_un", BrUn, 64'(f3 == 3'd6 || f3 == 3'd7));
    chk("in_ready_idle", in_ready, 64'd1);
    acc = br || jal || jalr;
    e = predict(br, jal, jalr, f3, pc_i, imm_i, rs1_i, eq, lt, pt, ptgt);
    if (acc) begin
      m_bcnt++;
      if (e.redir) m_mcnt++;
      e.bcnt = m_bcnt;
      e.mcnt = m_mcnt;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    clear_inputs();
    if (acc && e.redir) begin
      last = (hold_n < 0) ? 1 : hold_n;
      for (int k = 0; k <= last; k++) begin
        @(negedge clk);
        chk("wait_rv",    redirect_valid, 64'd1);
        chk("wait_flush", flush,          64'(k == 0));
        chk("wait_ready", in_ready,       64'd0);
        chk("wait_pc",    redirect_pc,    e.redirect_pc);
        redirect_ready = (hold_n >= 0) && (k == hold_n);
        // a candidate offered while the redirect is pending must be ignored
        in_valid  = (k != hold_n);
        is_branch = 1;
        funct3    = 3'($urandom_range(0, 7));
        pc        = {$urandom, $urandom};
        BrEq      = 1'($urandom);
        pred_taken = 1'($urandom);
        @(posedge clk); #1;
        clear_inputs();
        redirect_ready = 0;
      end
      if (hold_n >= 0) begin
        @(negedge clk);
        chk("release_rv",    redirect_valid, 64'd0);
        chk("release_ready", in_ready,       64'd1);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p, im, r, pt_tgt;
    bit          b, j, jr, pt;
    logic [2:0]  f;
    exp_t        e;
    int          kind;

    clear_inputs();
    redirect_ready = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_rv",       redirect_valid, 64'd0);
    chk("rst_ready",    in_ready,       64'd1);
    chk("rst_upd",      upd_valid,      64'd0);
    chk("rst_rpc",      redirect_pc,    64'd0);
    chk("rst_upd_pc",   upd_pc,         64'd0);
    chk("rst_upd_tgt",  upd_target,     64'd0);
    chk("rst_upd_tk",   upd_taken,      64'd0);
    chk("rst_bcnt",     branch_cnt,     64'd0);
    chk("rst_mcnt",     mispred_cnt,    64'd0);

    // BEQ taken, predicted not-taken
    issue(1, 0, 0, 3'b000, 64'h1000, 64'h40, 64'h0, 1, 0, 0, 64'h0, 0);
    // BLTU not taken, predicted not-taken
    issue(1, 0, 0, 3'b110, 64'h1200, 64'h80, 64'h0, 0, 0, 0, 64'h0, 0);
    // JALR correctly predicted, then wrong predicted target
    issue(0, 0, 1, 3'b000, 64'h1300, 64'h4, 64'h2001, 0, 0, 1, 64'h2004, 0);
    issue(0, 0, 1, 3'b000, 64'h1300, 64'h4, 64'h2001, 0, 0, 1, 64'h3000, 0);
    // Redirect stalled three cycles by fetch
    issue(1, 0, 0, 3'b001, 64'h4000, 64'h100, 64'h0, 0, 0, 0, 64'h0, 3);
    // JAL to misaligned target: exception, no redirect
    issue(0, 1, 0, 3'b000, 64'h100, 64'h2, 64'h0, 0, 0, 0, 64'h0, 0);
    // Illegal funct3: not taken; then with pred_taken=1 it redirects to pc+4
    issue(1, 0, 0, 3'b010, 64'h500, 64'h20, 64'h0, 1, 1, 0, 64'h0, 0);
    issue(1, 0, 0, 3'b011, 64'h600, 64'h20, 64'h0, 1, 1, 1, 64'h620, 0);
    // No class flag: in_valid ignored
    issue(0, 0, 0, 3'b000, 64'h700, 64'h20, 64'h0, 1, 1, 1, 64'h0, 0);

    // Reset while waiting on fetch
    issue(1, 0, 0, 3'b100, 64'h8000, 64'h10, 64'h0, 0, 1, 0, 64'h0, -1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    m_bcnt = 0; m_mcnt = 0;
    @(negedge clk);
    chk("wait_rst_rv",    redirect_valid, 64'd0);
    chk("wait_rst_ready", in_ready,       64'd1);
    chk("wait_rst_bcnt",  branch_cnt,     64'd0);
    chk("wait_rst_mcnt",  mispred_cnt,    64'd0);

    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      b  = (kind <= 5);
      j  = (kind == 6);
      jr = (kind == 7);
      f  = 3'($urandom_range(0, 7));
      p  = {$urandom, $urandom} & ~64'h3;
      if ($urandom_range(0, 3) == 0) im = {$urandom, $urandom};
      else im = {{52{1'b0}}, 12'($urandom)} & ~64'h3;
      if ($urandom_range(0, 1) == 0) im = -im;
      r  = {$urandom, $urandom};
      pt = 1'($urandom);
      e  = predict(b, j, jr, f, p, im, r, 0, 0, 0, 64'h0);
      pt_tgt = ($urandom_range(0, 2) != 0) ? e.upd_target : {$urandom, $urandom};
      issue(b, j, jr, f, p, im, r, 1'($urandom), 1'($urandom), pt, pt_tgt,
            $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
